r22sdf_bitrev_reorder: RTL and testbench

Output reorder buffer placed directly downstream of the 256-point R2²SDF FFT pipeline. The FFT stage chain emits bins in bit-reversed order. This block writes each frame into a ping-pong buffer at bit-reversed addresses and reads it back in natural bin order. It adds frame markers, a bin index and valid/ready backpressure on the output.

---
 rtl/r22sdf_pkg.sv | 30 +++
 rtl/r22sdf_dpram.sv | 31 +++
 rtl/r22sdf_bitrev_reorder.sv | 247 ++++++++++++++++++++++++
 tb/tb_r22sdf_bitrev_reorder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/r22sdf_pkg.sv
// Shared encodings and helpers for the R2^2SDF output reorder buffer.
// Holds bank/FSM state codes, the bit-reverse helper and the address-width derivation.
package r22sdf_pkg;

    // Widest address the bit-reverse helper supports (N up to 65536).
    localparam int unsigned max_aw = 16;

    localparam logic [1:0] BANK_EMPTY    = 2'd0;
    localparam logic [1:0] BANK_FULL     = 2'd1;
    localparam logic [1:0] BANK_DRAINING = 2'd2;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_FILL = 1'b1;

    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_DRAIN = 1'b1;

    function automatic int unsigned calc_aw(input int unsigned n);
        return $clog2(n);
    endfunction

    // Reverse the low aw bits of value; upper bits of the result are zero.
    function automatic logic [max_aw-1:0] bitrev(input logic [max_aw-1:0] value,
                                                 input int unsigned aw);
        logic [max_aw-1:0] rev;
        rev = {<<{value}};
        return rev >> (max_aw - aw);
    endfunction

endpackage

// File: rtl/r22sdf_dpram.sv
// Simple dual-port RAM: one write port, one read port, registered read data.
// Read data updates only on re and holds otherwise, so the read stage can stall in place.
module r22sdf_dpram
    import r22sdf_pkg::*;
#(
    parameter int unsigned data_w = 32,
    parameter int unsigned addr_w = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [addr_w-1:0] waddr,
    input  logic [data_w-1:0] wdata,
    input  logic              re,
    input  logic [addr_w-1:0] raddr,
    output logic [data_w-1:0] rdata
);

    localparam int unsigned depth = 1 << addr_w;

    logic [data_w-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/r22sdf_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT frames in, natural-order bins out with handshake.
// Optional R22SDF_REORDER_RESYNC_EN: a sof during a fill restarts the frame and flags overflow.
module r22sdf_bitrev_reorder
    import r22sdf_pkg::*;
#(
    parameter int unsigned data_resolution = 16,
    parameter int unsigned fft_length      = 256,
    localparam int unsigned addr_w         = calc_aw(fft_length)
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       din_valid,
    input  logic                       din_sof,
    input  logic [data_resolution-1:0] din_r,
    input  logic [data_resolution-1:0] din_i,
    input  logic                       dout_ready,
    output logic                       dout_valid,
    output logic                       dout_sof,
    output logic                       dout_eof,
    output logic [addr_w-1:0]          dout_idx,
    output logic [data_resolution-1:0] dout_r,
    output logic [data_resolution-1:0] dout_i,
    output logic                       overflow
);

    localparam int unsigned word_w = 2 * data_resolution;
    localparam logic [addr_w-1:0] last_idx = addr_w'(fft_length - 1);

    logic [0:0]        w_state_q, w_state_d;
    logic [addr_w-1:0] wcnt_q, wcnt_d;
    logic              wbank_q, wbank_d;
    logic [0:0]        r_state_q, r_state_d;
    logic [addr_w-1:0] rcnt_q, rcnt_d;
    logic              rbank_q, rbank_d;
    logic [1:0][1:0]   bank_q, bank_d;

    logic              ram_we, ram_re;
    logic [addr_w-1:0] ram_wlo;
    logic [word_w-1:0] ram_rdata;
    logic              overflow_c;
    logic              w_done, r_take, r_release, last_write_here, issue_ok;

    logic              rd_valid_q, rd_valid_d;
    logic [addr_w-1:0] rd_idx_q, rd_idx_d;
    logic              out_valid_q, out_valid_d;
    logic [word_w-1:0] out_word_q, out_word_d;
    logic [addr_w-1:0] out_idx_q, out_idx_d;
    logic              skid_valid_q, skid_valid_d;
    logic [word_w-1:0] skid_word_q, skid_word_d;
    logic [addr_w-1:0] skid_idx_q, skid_idx_d;
    logic              push, pop;

    // Write side
    always_comb begin
        w_state_d  = w_state_q;
        wcnt_d     = wcnt_q;
        wbank_d    = wbank_q;
        ram_we     = 1'b0;
        ram_wlo    = '0;
        overflow_c = 1'b0;
        w_done     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (din_valid && din_sof) begin
                    if (bank_q[wbank_q] == BANK_EMPTY) begin
                        ram_we    = 1'b1;
                        wcnt_d    = addr_w'(1);
                        w_state_d = W_FILL;
                    end else begin
                        overflow_c = 1'b1;
                    end
                end
            end
            W_FILL: begin
                if (din_valid) begin
`ifdef R22SDF_REORDER_RESYNC_EN
                    if (din_sof) begin
                        ram_we     = 1'b1;
                        wcnt_d     = addr_w'(1);
                        overflow_c = 1'b1;
                    end else begin
`else
                    begin
`endif
                        ram_we  = 1'b1;
                        ram_wlo = addr_w'(bitrev(max_aw'(wcnt_q), addr_w));
                        wcnt_d  = wcnt_q + addr_w'(1);
                        if (wcnt_q == last_idx) begin
                            w_done    = 1'b1;
                            wbank_d   = ~wbank_q;
                            w_state_d = W_IDLE;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // A frame finishing this cycle can start draining at once; bin 0 was written long ago.
    assign last_write_here = w_done && (wbank_q == rbank_q);
    assign issue_ok        = !(out_valid_q && skid_valid_q);

    // Read side: rcnt_q is always zero in R_IDLE, so the read address needs no mux.
    always_comb begin
        r_state_d = r_state_q;
        rcnt_d    = rcnt_q;
        rbank_d   = rbank_q;
        ram_re    = 1'b0;
        r_take    = 1'b0;
        r_release = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (bank_q[rbank_q] == BANK_FULL || last_write_here) begin
                    r_take    = 1'b1;
                    r_state_d = R_DRAIN;
                    if (issue_ok) begin
                        ram_re = 1'b1;
                        rcnt_d = addr_w'(1);
                    end
                end
            end
            R_DRAIN: begin
                if (issue_ok) begin
                    ram_re = 1'b1;
                    rcnt_d = rcnt_q + addr_w'(1);
                    if (rcnt_q == last_idx) begin
                        r_release = 1'b1;
                        rbank_d   = ~rbank_q;
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    // Writer and reader only ever touch different banks, except the same-cycle hand-over
    // where the reader's DRAINING must win over the writer's FULL.
    always_comb begin
        bank_d = bank_q;
        if (w_done) begin
            bank_d[wbank_q] = BANK_FULL;
        end
        if (r_take) begin
            bank_d[rbank_q] = BANK_DRAINING;
        end
        if (r_release) begin
            bank_d[rbank_q] = BANK_EMPTY;
        end
    end

    r22sdf_dpram #(
        .data_w(word_w),
        .addr_w(addr_w + 1)
    ) u_ram (
        .clk  (sys_clk),
        .we   (ram_we),
        .waddr({wbank_q, ram_wlo}),
        .wdata({din_r, din_i}),
        .re   (ram_re),
        .raddr({rbank_q, rcnt_q}),
        .rdata(ram_rdata)
    );

    // Output stage: RAM read register feeds a two-entry queue (output register + skid).
    assign push = rd_valid_q && !(out_valid_q && skid_valid_q);
    assign pop  = out_valid_q && dout_ready;

    always_comb begin
        rd_valid_d   = ram_re ? 1'b1 : (push ? 1'b0 : rd_valid_q);
        rd_idx_d     = ram_re ? rcnt_q : rd_idx_q;
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        out_idx_d    = out_idx_q;
        skid_valid_d = skid_valid_q;
        skid_word_d  = skid_word_q;
        skid_idx_d   = skid_idx_q;
        if (!out_valid_q) begin
            if (push) begin
                out_valid_d = 1'b1;
                out_word_d  = ram_rdata;
                out_idx_d   = rd_idx_q;
            end
        end else if (!skid_valid_q) begin
            if (pop && push) begin
                out_word_d = ram_rdata;
                out_idx_d  = rd_idx_q;
            end else if (pop) begin
                out_valid_d = 1'b0;
            end else if (push) begin
                skid_valid_d = 1'b1;
                skid_word_d  = ram_rdata;
                skid_idx_d   = rd_idx_q;
            end
        end else if (pop) begin
            out_word_d   = skid_word_q;
            out_idx_d    = skid_idx_q;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            w_state_q    <= W_IDLE;
            wcnt_q       <= '0;
            wbank_q      <= 1'b0;
            r_state_q    <= R_IDLE;
            rcnt_q       <= '0;
            rbank_q      <= 1'b0;
            bank_q       <= {BANK_EMPTY, BANK_EMPTY};
            rd_valid_q   <= 1'b0;
            rd_idx_q     <= '0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_idx_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_word_q  <= '0;
            skid_idx_q   <= '0;
        end else begin
            w_state_q    <= w_state_d;
            wcnt_q       <= wcnt_d;
            wbank_q      <= wbank_d;
            r_state_q    <= r_state_d;
            rcnt_q       <= rcnt_d;
            rbank_q      <= rbank_d;
            bank_q       <= bank_d;
            rd_valid_q   <= rd_valid_d;
            rd_idx_q     <= rd_idx_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            out_idx_q    <= out_idx_d;
            skid_valid_q <= skid_valid_d;
            skid_word_q  <= skid_word_d;
            skid_idx_q   <= skid_idx_d;
        end
    end

    assign dout_valid = out_valid_q;
    assign dout_sof   = out_valid_q && (out_idx_q == '0);
    assign dout_eof   = out_valid_q && (out_idx_q == last_idx);
    assign dout_idx   = out_idx_q;
    assign dout_r     = out_word_q[word_w-1:data_resolution];
    assign dout_i     = out_word_q[data_resolution-1:0];
    assign overflow   = overflow_c && !sys_rst;

endmodule

// File: tb/tb_r22sdf_bitrev_reorder.sv
// Directed bench for r22sdf_bitrev_reorder at fft_length=16.
// Checks reorder, latency, throughput, backpressure, overflow and reset recovery.
module tb_r22sdf_bitrev_reorder;

    localparam int unsigned DW = 16;
    localparam int unsigned N  = 16;
    localparam int unsigned AW = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          din_valid;
    logic          din_sof;
    logic [DW-1:0] din_r;
    logic [DW-1:0] din_i;
    logic          dout_ready;
    logic          dout_valid;
    logic          dout_sof;
    logic          dout_eof;
    logic [AW-1:0] dout_idx;
    logic [DW-1:0] dout_r;
    logic [DW-1:0] dout_i;
    logic          overflow;

    r22sdf_bitrev_reorder #(
        .data_resolution(DW),
        .fft_length     (N)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .din_valid (din_valid),
        .din_sof   (din_sof),
        .din_r     (din_r),
        .din_i     (din_i),
        .dout_ready(dout_ready),
        .dout_valid(dout_valid),
        .dout_sof  (dout_sof),
        .dout_eof  (dout_eof),
        .dout_idx  (dout_idx),
        .dout_r    (dout_r),
        .dout_i    (dout_i),
        .overflow  (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Natural bin n holds input sample bitrev4(n).
    int bitrev_order [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    logic [DW-1:0] q_r   [$];
    logic [DW-1:0] q_i   [$];
    logic [AW-1:0] q_idx [$];
    logic          q_sof [$];
    logic          q_eof [$];
    int            valid_cnt, run_len, max_run, first_valid_cyc, ovf_cnt, ovf_cyc, stall_viol;
    logic          prev_stall;
    logic [38:0]   prev_snap;
    logic [38:0]   snap_now;

    assign snap_now = {dout_valid, dout_sof, dout_eof, dout_idx, dout_r, dout_i};

    always @(negedge sys_clk) begin
        if (dout_valid) begin
            valid_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end else begin
            run_len = 0;
        end
        if (dout_valid && dout_ready) begin
            q_r.push_back(dout_r);
            q_i.push_back(dout_i);
            q_idx.push_back(dout_idx);
            q_sof.push_back(dout_sof);
            q_eof.push_back(dout_eof);
        end
        if (overflow) begin
            ovf_cnt++;
            ovf_cyc = cyc;
        end
        if (prev_stall && snap_now !== prev_snap) stall_viol++;
        prev_stall = dout_valid && !dout_ready;
        prev_snap  = snap_now;
    end

    task automatic clear_mon();
        q_r.delete();
        q_i.delete();
        q_idx.delete();
        q_sof.delete();
        q_eof.delete();
        valid_cnt       = 0;
        run_len         = 0;
        max_run         = 0;
        first_valid_cyc = -1;
        ovf_cnt         = 0;
        ovf_cyc         = -1;
        stall_viol      = 0;
        prev_stall      = 1'b0;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input int val);
        din_valid = v;
        din_sof   = s;
        din_r     = DW'(val);
        din_i     = DW'(-val);
        tick();
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        din_sof   = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send_frame(input int base, output int t_last);
        t_last = 0;
        for (int k = 0; k < N; k++) begin
            t_last = cyc;
            drive(1'b1, k == 0, base + k);
        end
        din_valid = 1'b0;
        din_sof   = 1'b0;
    endtask

    task automatic check_frame(input int base, input string tag);
        int v;
        for (int n = 0; n < N; n++) begin
            if (q_r.size() > 0) begin
                v = base + bitrev_order[n];
                chk({tag, " r"}, int'(q_r.pop_front()), v & 32'hFFFF);
                chk({tag, " i"}, int'(q_i.pop_front()), (-v) & 32'hFFFF);
                chk({tag, " idx"}, int'(q_idx.pop_front()), n);
                chk({tag, " sof"}, int'(q_sof.pop_front()), (n == 0) ? 1 : 0);
                chk({tag, " eof"}, int'(q_eof.pop_front()), (n == N - 1) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int t1, t2, t3;

        sys_rst    = 1'b1;
        din_valid  = 1'b0;
        din_sof    = 1'b0;
        din_r      = '0;
        din_i      = '0;
        dout_ready = 1'b1;
        clear_mon();
        tick();
        tick();
        tick();
        chk("rst valid", int'(dout_valid), 0);
        chk("rst sof", int'(dout_sof), 0);
        chk("rst eof", int'(dout_eof), 0);
        chk("rst idx", int'(dout_idx), 0);
        chk("rst r", int'(dout_r), 0);
        chk("rst i", int'(dout_i), 0);
        chk("rst overflow", int'(overflow), 0);
        sys_rst = 1'b0;
        idle(2);

        // Single frame: reorder and latency
        clear_mon();
        send_frame(0, t1);
        idle(25);
        chk("f1 count", q_r.size(), N);
        chk("f1 latency", first_valid_cyc, t1 + 2);
        chk("f1 overflow", ovf_cnt, 0);
        check_frame(0, "f1");

        // Three back-to-back frames with ready high
        clear_mon();
        send_frame(100, t1);
        send_frame(200, t2);
        send_frame(300, t3);
        idle(30);
        chk("b2b count", q_r.size(), 3 * N);
        chk("b2b continuous", max_run, 3 * N);
        chk("b2b overflow", ovf_cnt, 0);
        check_frame(100, "b2b0");
        check_frame(200, "b2b1");
        check_frame(300, "b2b2");

        // Backpressure: two frames stored, third dropped
        dout_ready = 1'b0;
        clear_mon();
        send_frame(1000, t1);
        send_frame(2000, t2);
        send_frame(3000, t3);
        idle(10);
        chk("bp overflow count", ovf_cnt, 1);
        chk("bp overflow cycle", ovf_cyc, t2 + 1);
        chk("bp no transfer", q_r.size(), 0);
        chk("bp head valid", int'(dout_valid), 1);
        chk("bp head r", int'(dout_r), 1000);
        dout_ready = 1'b1;
        idle(50);
        chk("bp count", q_r.size(), 2 * N);
        chk("bp stable", stall_viol, 0);
        chk("bp overflow final", ovf_cnt, 1);
        check_frame(1000, "bp0");
        check_frame(2000, "bp1");

        // Samples without sof are discarded
        clear_mon();
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 77 + k);
        send_frame(500, t1);
        idle(25);
        chk("nosof count", q_r.size(), N);
        chk("nosof overflow", ovf_cnt, 0);
        check_frame(500, "nosof");

        // Reset during frame 2 fill while frame 1 drains
        clear_mon();
        send_frame(600, t1);
        for (int k = 0; k < 7; k++) drive(1'b1, k == 0, 700 + k);
        sys_rst = 1'b1;
        drive(1'b1, 1'b0, 707);
        sys_rst   = 1'b0;
        din_valid = 1'b0;
        chk("mrst pre-reset bins", (q_r.size() > 0) ? 1 : 0, 1);
        chk("mrst valid", int'(dout_valid), 0);
        chk("mrst sof", int'(dout_sof), 0);
        chk("mrst eof", int'(dout_eof), 0);
        chk("mrst idx", int'(dout_idx), 0);
        chk("mrst r", int'(dout_r), 0);
        chk("mrst i", int'(dout_i), 0);
        chk("mrst overflow", int'(overflow), 0);
        clear_mon();
        idle(40);
        chk("mrst quiet", valid_cnt, 0);
        send_frame(800, t1);
        idle(25);
        chk("mrst count", q_r.size(), N);
        chk("mrst latency", first_valid_cyc, t1 + 2);
        check_frame(800, "mrst");

`ifdef R22SDF_REORDER_RESYNC_EN
        // sof mid-fill restarts the frame
        clear_mon();
        for (int k = 0; k < 6; k++) drive(1'b1, k == 0, 900 + k);
        send_frame(950, t1);
        idle(25);
        chk("resync overflow", ovf_cnt, 1);
        chk("resync count", q_r.size(), N);
        check_frame(950, "resync");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
